cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares one memory-side read/write port between the instruction cache (read-only) and the data cache (read + line write-back).
- The memory port uses the same rd/ret/wr protocol the caches drive.
- One read is outstanding at a time, with round-robin grant. A one-entry write buffer decouples dcache write-backs.
- The block sits between the two caches and the AXI bridge.

Parameters:
LINE_LSB, 4, number of low address bits ignored when comparing a read address against the buffered write (16-byte line).
RAW_CHECK, 1, when 1 a dcache read to the buffered-write line is stalled until that write drains; when 0 no check is made.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous active-high reset.
ic_rd_req  in  1  icache read request.
ic_rd_type  in  3  icache read type (3'b100 = line).
ic_rd_addr  in  32  icache read address.
ic_rd_rdy  out  1  icache request accepted this cycle.
ic_ret_valid  out  1  icache return beat valid.
ic_ret_last  out  1  icache last return beat.
ic_ret_data  out  32  icache return data.
dc_rd_req / dc_rd_type / dc_rd_addr / dc_rd_rdy / dc_ret_valid / dc_ret_last / dc_ret_data  as the ic_ ports, for the dcache.
dc_wr_req  in  1  dcache write request.
dc_wr_type  in  3  write type.
dc_wr_addr  in  32  write address.
dc_wr_wstrb  in  4  write byte strobe.
dc_wr_data  in  128  write data.
dc_wr_rdy  out  1  write buffer empty; the write is accepted when dc_wr_req & dc_wr_rdy.
mem_rd_req  out  1  memory read request.
mem_rd_type  out  3  memory read type.
mem_rd_addr  out  32  memory read address.
mem_rd_rdy  in  1  memory accepts the read.
mem_ret_valid  in  1  memory return beat valid.
mem_ret_last  in  1  memory last return beat.
mem_ret_data  in  32  memory return data.
mem_wr_req  out  1  memory write request.
mem_wr_type  out  3  memory write type.
mem_wr_addr  out  32  memory write address.
mem_wr_wstrb  out  4  memory write byte strobe.
mem_wr_data  out  128  memory write data.
mem_wr_rdy  in  1  memory accepts the write.

Behaviour:
Reset:
- On reset: read FSM = IDLE, last_grant = icache (so the dcache wins the first tie), write buffer empty.
- All req/valid/rdy outputs are 0 while reset is asserted, except dc_wr_rdy = 0 during reset and 1 from the first cycle after reset.
- Data and address outputs are 0.

Read FSM states: IDLE, WAIT_IC, WAIT_DC.

IDLE:
- Eligible requesters: ic_rd_req, and dc_rd_req provided it is not RAW-blocked.
- Both eligible: grant the one not equal to last_grant.
- Grant is combinational: mem_rd_req/type/addr = the granted requester's fields.
- mem_rd_rdy is routed only to the granted requester's *_rd_rdy; the other requester's rdy = 0.
- On mem_rd_req & mem_rd_rdy: last_grant <= granted requester; next state = WAIT_IC or WAIT_DC.
- Grant may change between cycles while unaccepted. Requesters hold their request until their rdy.

WAIT_x:
- mem_rd_req = 0; both *_rd_rdy = 0.
- mem_ret_valid/last/data are routed to the owner's ret_ outputs. The non-owner's ret_valid/ret_last = 0 and its ret_data = 0.
- On mem_ret_valid & mem_ret_last: return to IDLE.
- A new grant can be issued no earlier than the cycle after the last beat. Read turnaround is therefore at least 1 idle cycle.

RAW block:
- Applies when RAW_CHECK = 1, the write buffer is full, and dc_rd_addr[31:LINE_LSB] == wbuf_addr[31:LINE_LSB].
- While blocked, the dcache read is not eligible; the icache may still be granted.

Write buffer:
- dc_wr_rdy = ~full.
- On dc_wr_req & dc_wr_rdy: latch type/addr/wstrb/data and set full.
- While full: mem_wr_req = 1 with the buffered fields.
- On mem_wr_rdy: clear full. dc_wr_rdy is 1 in the next cycle, so there is no same-cycle refill (max 1 write per 2 cycles).
- The write path is independent of the read FSM; a read and a write may be issued to memory in the same cycle.

Boundary cases:
- A return beat arriving in IDLE (mem_ret_valid) is ignored: it is not forwarded to either cache. It is an assertion failure in verification.
- mem_ret_last without mem_ret_valid has no effect.
- Reset asserted mid-burst or with the buffer full: the FSM goes to IDLE and the buffer empties immediately. The pending write is dropped.

Test Plan:
- Dcache only: dc_rd_addr = 0x1C000040, mem_rd_rdy = 1 → mem_rd_addr = 0x1C000040 and dc_rd_rdy = 1 in the same cycle; 4 beats 0x11..0x44 appear on dc_ret_data with dc_ret_last on beat 4; ic_ret_valid stays 0.
- Simultaneous ic/dc requests from reset → dcache granted first. After its last beat plus 1 cycle, the icache is granted. A repeated tie alternates.
- Dcache write 0x1C000100 with mem_wr_rdy = 0 for 3 cycles → mem_wr_req held for 3 cycles with the buffered data, dc_wr_rdy = 0 during that time, and dc_wr_rdy = 1 the cycle after the mem_wr_rdy pulse.
- RAW: buffer holds 0x1C000100; dc_rd_addr = 0x1C00010C and ic_rd_req = 1 → icache granted, dcache not granted until the write drains. With dc_rd_addr = 0x1C000110 the dcache is eligible immediately.
- Read and write issued in the same cycle → both mem_rd_req and mem_wr_req are 1, and each completes its own handshake.
- Reset asserted on beat 2 of a 4-beat return → outputs are 0 immediately, the FSM is IDLE, and a new request after reset is granted normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one memory read/write port between the icache (reads) and the dcache
// (reads plus line write-back). Round-robin read grant, one-entry write buffer.
module cache_mem_arbiter #(
  parameter int LINE_LSB  = 4,
  parameter bit RAW_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,

  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,

  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_wstrb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,

  output logic         mem_rd_req,
  output logic [2:0]   mem_rd_type,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_rdy,
  input  logic         mem_ret_valid,
  input  logic         mem_ret_last,
  input  logic [31:0]  mem_ret_data,

  output logic         mem_wr_req,
  output logic [2:0]   mem_wr_type,
  output logic [31:0]  mem_wr_addr,
  output logic [3:0]   mem_wr_wstrb,
  output logic [127:0] mem_wr_data,
  input  logic         mem_wr_rdy
);

  typedef enum logic [1:0] {IDLE, WAIT_IC, WAIT_DC} state_t;

  state_t         state, state_next;
  logic           last_dc;
  logic           wbuf_full;
  logic [2:0]     wbuf_type;
  logic [31:0]    wbuf_addr;
  logic [3:0]     wbuf_wstrb;
  logic [127:0]   wbuf_data;

  logic raw_block, ic_elig, dc_elig, grant_dc, grant_any, rd_accept, wr_accept;

  // A dcache read must not overtake a pending write-back to the same line.
  assign raw_block = RAW_CHECK && wbuf_full &&
                     (dc_rd_addr[31:LINE_LSB] == wbuf_addr[31:LINE_LSB]);
  assign ic_elig   = ic_rd_req & ~reset;
  assign dc_elig   = dc_rd_req & ~raw_block & ~reset;
  assign grant_dc  = dc_elig & (~ic_elig | ~last_dc);
  assign grant_any = (state == IDLE) & (ic_elig | dc_elig);
  assign rd_accept = grant_any & mem_rd_rdy;
  assign wr_accept = dc_wr_req & ~wbuf_full & ~reset;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_dc   <= 1'b0;
      wbuf_full <= 1'b0;
    end else begin
      state <= state_next;
      if (rd_accept) last_dc <= grant_dc;
      if (wbuf_full && mem_wr_rdy) wbuf_full <= 1'b0;
      else if (wr_accept)          wbuf_full <= 1'b1;
    end
  end

  // NOTE: the buffered write fields carry no reset; they are only observed
  // through outputs gated by wbuf_full, which itself is reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wbuf_type  <= dc_wr_type;
      wbuf_addr  <= dc_wr_addr;
      wbuf_wstrb <= dc_wr_wstrb;
      wbuf_data  <= dc_wr_data;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next   = state;
    mem_rd_req   = 1'b0;
    mem_rd_type  = '0;
    mem_rd_addr  = '0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    ic_ret_data  = '0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    dc_ret_data  = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          mem_rd_req = 1'b1;
          if (grant_dc) begin
            mem_rd_type = dc_rd_type;
            mem_rd_addr = dc_rd_addr;
            dc_rd_rdy   = mem_rd_rdy;
          end else begin
            mem_rd_type = ic_rd_type;
            mem_rd_addr = ic_rd_addr;
            ic_rd_rdy   = mem_rd_rdy;
          end
          if (mem_rd_rdy) state_next = grant_dc ? WAIT_DC : WAIT_IC;
        end
      end
      WAIT_IC: begin
        ic_ret_valid = mem_ret_valid;
        ic_ret_last  = mem_ret_last;
        ic_ret_data  = mem_ret_data;
        if (mem_ret_valid && mem_ret_last) state_next = IDLE;
      end
      WAIT_DC: begin
        dc_ret_valid = mem_ret_valid;
        dc_ret_last  = mem_ret_last;
        dc_ret_data  = mem_ret_data;
        if (mem_ret_valid && mem_ret_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dc_wr_rdy    = ~wbuf_full & ~reset;
  assign mem_wr_req   = wbuf_full;
  assign mem_wr_type  = wbuf_full ? wbuf_type  : '0;
  assign mem_wr_addr  = wbuf_full ? wbuf_addr  : '0;
  assign mem_wr_wstrb = wbuf_full ? wbuf_wstrb : '0;
  assign mem_wr_data  = wbuf_full ? wbuf_data  : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change 1ns after the rising
// edge, outputs are compared on the falling edge.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
  logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0]  dc_ret_data;
  logic         dc_wr_rdy;
  logic         mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [2:0]   mem_rd_type, mem_wr_type;
  logic [31:0]  mem_rd_addr, mem_ret_data, mem_wr_addr;
  logic         mem_wr_req, mem_wr_rdy;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] WDATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  cache_mem_arbiter #(.LINE_LSB(4), .RAW_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
    .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a single last beat into the current read and steps past it.
  task automatic last_beat(input logic [31:0] data);
    mem_ret_valid = 1'b1;
    mem_ret_last  = 1'b1;
    mem_ret_data  = data;
    tick();
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C000200;
    dc_rd_req = 1'b1; dc_rd_type = 3'b100; dc_rd_addr = 32'h1C000300;
    dc_wr_req = 1'b0; dc_wr_type = 3'b100; dc_wr_addr = '0;
    dc_wr_wstrb = 4'hF; dc_wr_data = '0;
    mem_rd_rdy = 1'b1; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
    mem_wr_rdy = 1'b0;

    // Reset holds every handshake output low even with requests pending.
    @(negedge clk);
    check("rst_mem_rd_req", mem_rd_req, 0);
    check("rst_dc_rd_rdy", dc_rd_rdy, 0);
    check("rst_ic_rd_rdy", ic_rd_rdy, 0);
    check("rst_dc_wr_rdy", dc_wr_rdy, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_mem_wr_req", mem_wr_req, 0);
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    tick();
    reset = 1'b0;

    // Dcache-only read with a 4-beat return.
    dc_rd_req = 1'b1; dc_rd_addr = 32'h1C000040;
    @(negedge clk);
    check("t1_mem_rd_req", mem_rd_req, 1);
    check("t1_mem_rd_addr", mem_rd_addr, 32'h1C000040);
    check("t1_mem_rd_type", mem_rd_type, 3'b100);
    check("t1_dc_rd_rdy", dc_rd_rdy, 1);
    check("t1_ic_rd_rdy", ic_rd_rdy, 0);
    check("t1_dc_wr_rdy", dc_wr_rdy, 1);
    tick();
    dc_rd_req = 1'b0;
    mem_ret_last = 1'b1;
    @(negedge clk);
    check("t1_last_no_valid", dc_ret_valid, 0);
    check("t1_wait_no_req", mem_rd_req, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ret_valid = 1'b1;
      mem_ret_last  = (i == 3);
      mem_ret_data  = 32'h11 * (i + 1);
      @(negedge clk);
      check("t1_dc_ret_valid", dc_ret_valid, 1);
      check("t1_dc_ret_data", dc_ret_data, 32'h11 * (i + 1));
      check("t1_dc_ret_last", dc_ret_last, (i == 3));
      check("t1_ic_ret_valid", ic_ret_valid, 0);
      tick();
    end
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

    // Tie from reset: dcache first, then the tie alternates.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C000200;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h1C000300;
    @(negedge clk);
    check("t2_tie1_addr", mem_rd_addr, 32'h1C000300);
    check("t2_tie1_dc_rdy", dc_rd_rdy, 1);
    check("t2_tie1_ic_rdy", ic_rd_rdy, 0);
    tick();
    dc_rd_req = 1'b0;
    @(negedge clk);
    check("t2_wait_ic_rdy", ic_rd_rdy, 0);
    check("t2_wait_rd_req", mem_rd_req, 0);
    last_beat(32'hAA);
    dc_rd_req = 1'b1;
    @(negedge clk);
    check("t2_tie2_addr", mem_rd_addr, 32'h1C000200);
    check("t2_tie2_ic_rdy", ic_rd_rdy, 1);
    check("t2_tie2_dc_rdy", dc_rd_rdy, 0);
    tick();
    ic_rd_req = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hBB;
    @(negedge clk);
    check("t2_ic_ret_data", ic_ret_data, 32'hBB);
    check("t2_dc_ret_valid", dc_ret_valid, 0);
    check("t2_dc_ret_data", dc_ret_data, 0);
    tick();
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    ic_rd_req = 1'b1;
    @(negedge clk);
    check("t2_tie3_addr", mem_rd_addr, 32'h1C000300);
    check("t2_tie3_dc_rdy", dc_rd_rdy, 1);
    tick();
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    last_beat(32'h0);

    // Write-back held off by memory for three cycles.
    dc_wr_req = 1'b1; dc_wr_addr = 32'h1C000100; dc_wr_data = WDATA; dc_wr_wstrb = 4'hF;
    @(negedge clk);
    check("t3_wr_rdy_empty", dc_wr_rdy, 1);
    check("t3_wr_req_empty", mem_wr_req, 0);
    tick();
    dc_wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_wr_req_held", mem_wr_req, 1);
      check("t3_wr_rdy_full", dc_wr_rdy, 0);
      check("t3_wr_data", mem_wr_data, WDATA);
      tick();
    end
    check("t3_wr_addr", mem_wr_addr, 32'h1C000100);
    check("t3_wr_wstrb", mem_wr_wstrb, 4'hF);
    mem_wr_rdy = 1'b1;
    @(negedge clk);
    check("t3_wr_rdy_pulse", dc_wr_rdy, 0);
    tick();
    mem_wr_rdy = 1'b0;
    @(negedge clk);
    check("t3_wr_rdy_after", dc_wr_rdy, 1);
    check("t3_wr_req_after", mem_wr_req, 0);
    check("t3_wr_addr_after", mem_wr_addr, 0);

    // RAW: same-line dcache read waits for the write to drain.
    tick();
    dc_wr_req = 1'b1;
    tick();
    dc_wr_req = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h1C00010C;
    mem_rd_rdy = 1'b1;
    @(negedge clk);
    check("t4_blocked_rd_req", mem_rd_req, 0);
    check("t4_blocked_dc_rdy", dc_rd_rdy, 0);
    tick();
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C000400;
    @(negedge clk);
    check("t4_ic_addr", mem_rd_addr, 32'h1C000400);
    check("t4_ic_rdy", ic_rd_rdy, 1);
    check("t4_dc_rdy", dc_rd_rdy, 0);
    tick();
    ic_rd_req = 1'b0;
    last_beat(32'hCC);
    mem_wr_rdy = 1'b1;
    @(negedge clk);
    check("t4_still_blocked", mem_rd_req, 0);
    tick();
    mem_wr_rdy = 1'b0;
    @(negedge clk);
    check("t4_drained_addr", mem_rd_addr, 32'h1C00010C);
    check("t4_drained_dc_rdy", dc_rd_rdy, 1);
    tick();
    dc_rd_req = 1'b0;
    last_beat(32'h0);

    // Other-line read beside a full buffer: read and write in the same cycle.
    dc_wr_req = 1'b1;
    tick();
    dc_wr_req = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h1C000110;
    mem_wr_rdy = 1'b1;
    @(negedge clk);
    check("t5_rd_req", mem_rd_req, 1);
    check("t5_wr_req", mem_wr_req, 1);
    check("t5_dc_rd_rdy", dc_rd_rdy, 1);
    check("t5_rd_addr", mem_rd_addr, 32'h1C000110);
    tick();
    dc_rd_req = 1'b0; mem_wr_rdy = 1'b0;
    @(negedge clk);
    check("t5_wr_done", mem_wr_req, 0);
    check("t5_wr_rdy", dc_wr_rdy, 1);
    check("t5_rd_waiting", mem_rd_req, 0);
    last_beat(32'h0);

    // Reset on beat 2 of a burst with the buffer full.
    dc_rd_req = 1'b1; dc_rd_addr = 32'h1C000500;
    dc_wr_req = 1'b1; dc_wr_addr = 32'h1C000600;
    tick();
    dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_data = 32'h11;
    @(negedge clk);
    check("t6_beat1", dc_ret_data, 32'h11);
    check("t6_wr_full", mem_wr_req, 1);
    tick();
    mem_ret_data = 32'h22;
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_ret_valid", dc_ret_valid, 0);
    check("t6_rst_ret_data", dc_ret_data, 0);
    check("t6_rst_wr_req", mem_wr_req, 0);
    check("t6_rst_wr_data", mem_wr_data, 0);
    check("t6_rst_wr_rdy", dc_wr_rdy, 0);
    tick();
    reset = 1'b0; mem_ret_valid = 1'b0;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C000700;
    @(negedge clk);
    check("t6_post_wr_rdy", dc_wr_rdy, 1);
    check("t6_post_wr_req", mem_wr_req, 0);
    check("t6_post_ic_rdy", ic_rd_rdy, 1);
    check("t6_post_addr", mem_rd_addr, 32'h1C000700);
    tick();
    ic_rd_req = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hDD;
    @(negedge clk);
    check("t6_post_ret", ic_ret_data, 32'hDD);
    check("t6_post_ret_valid", ic_ret_valid, 1);
    tick();
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
